// File: rtl/branch_history_table.sv
// branch_history_table
//   Direction predictor made of NR_ENTRIES two-bit saturating counters.
//   The entries form ROWS rows by INSTR_PER_FETCH columns. The row is picked
//   by fetch-block PC bits and the column by the instruction slot. The
//   predictor returns one prediction per slot of the current fetch block.
//   Resolved conditional branches train it. There are no tags, so PCs that
//   share the index bits also share an entry.
//
// Ports
//   clk_i          core clock
//   rst_ni         asynchronous active-low reset (clears all entries)
//   flush_bp_i     synchronous clear of all predictor state; wins over update
//   debug_mode_i   suppresses training while the core is in debug mode
//   vpc_i          virtual PC of the current fetch block (prediction read)
//   update_valid_i single-cycle pulse: a resolved branch is presented
//   update_pc_i    PC of the resolved branch
//   update_taken_i resolved direction (1 = taken)
//   pred_valid_o   per slot: entry has been trained
//   pred_taken_o   per slot: predicted taken (valid & counter MSB)
//
// INSTR_PER_FETCH is assumed to be at least 2, so that the column field is
// non-empty.

module branch_history_table #(
    parameter int unsigned XLEN            = 64,
    parameter int unsigned NR_ENTRIES      = 128,
    parameter int unsigned INSTR_PER_FETCH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_bp_i,
    input  logic                       debug_mode_i,
    input  logic [XLEN-1:0]            vpc_i,
    input  logic                       update_valid_i,
    input  logic [XLEN-1:0]            update_pc_i,
    input  logic                       update_taken_i,
    output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
    output logic [INSTR_PER_FETCH-1:0] pred_taken_o
);

    localparam int unsigned ROWS    = NR_ENTRIES / INSTR_PER_FETCH;
    localparam int unsigned OFS     = $clog2(INSTR_PER_FETCH);
    localparam int unsigned IDX     = $clog2(ROWS);
    localparam int unsigned ENTRY_W = OFS + IDX;

    // Saturating counter step: never wraps past 0 or 3.
    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (cnt == 2'd3) ? 2'd3 : cnt + 2'd1;
        end else begin
            res = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
        end
        return res;
    endfunction

    // Flat storage: entry index = {row, column} = pc[1 +: ENTRY_W].
    logic [NR_ENTRIES-1:0]      valid_r;
    logic [NR_ENTRIES-1:0][1:0] cnt_r;

    logic                 upd_en_s;
    logic [ENTRY_W-1:0]   upd_idx_s;
    logic [1:0]           upd_cnt_s;
    logic [IDX-1:0]       rd_row_s;
    logic                 unused_s;

    // The MSBs and bit 0 of both PCs are deliberately ignored (aliasing intended).
    assign unused_s = ^{vpc_i, update_pc_i};

    assign upd_en_s  = update_valid_i & ~debug_mode_i & ~flush_bp_i;
    assign upd_idx_s = update_pc_i[1 +: ENTRY_W];
    assign rd_row_s  = vpc_i[1 + OFS +: IDX];

    // New counter value for the trained entry: first training lands in a weak state.
    always_comb begin
        upd_cnt_s = 2'd0;
        if (valid_r[upd_idx_s]) begin
            upd_cnt_s = sat_step(cnt_r[upd_idx_s], update_taken_i);
        end else begin
            upd_cnt_s = update_taken_i ? 2'd2 : 2'd1;
        end
    end

    // Predictor state: async reset, flush clear, or a single-entry write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_r <= '0;
            cnt_r   <= '0;
        end else if (flush_bp_i) begin
            valid_r <= '0;
            cnt_r   <= '0;
        end else if (upd_en_s) begin
            valid_r[upd_idx_s] <= 1'b1;
            cnt_r[upd_idx_s]   <= upd_cnt_s;
        end else begin
            valid_r <= valid_r;
            cnt_r   <= cnt_r;
        end
    end

    // Zero-latency read of the addressed row; there is no bypass of a same-cycle write.
    for (genvar i = 0; i < INSTR_PER_FETCH; i++) begin : g_slot
        localparam logic [OFS-1:0] COL = OFS'(i);
        logic [ENTRY_W-1:0] rd_idx_s;
        assign rd_idx_s        = {rd_row_s, COL};
        assign pred_valid_o[i] = valid_r[rd_idx_s];
        assign pred_taken_o[i] = valid_r[rd_idx_s] & cnt_r[rd_idx_s][1];
    end

endmodule

// File: tb/tb_branch_history_table.sv
module tb_branch_history_table;

    logic        clk_i;
    logic        rst_ni;
    logic        flush_bp_i;
    logic        debug_mode_i;
    logic [63:0] vpc_i;
    logic        update_valid_i;
    logic [63:0] update_pc_i;
    logic        update_taken_i;
    logic [1:0]  pred_valid_o;
    logic [1:0]  pred_taken_o;

    int n_checks = 0;
    int n_fail   = 0;

    branch_history_table #(
        .XLEN(64), .NR_ENTRIES(128), .INSTR_PER_FETCH(2)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_bp_i(flush_bp_i),
        .debug_mode_i(debug_mode_i), .vpc_i(vpc_i),
        .update_valid_i(update_valid_i), .update_pc_i(update_pc_i),
        .update_taken_i(update_taken_i),
        .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // One single-cycle update pulse; returns on the negedge after the capturing edge.
    task automatic pulse_update(input logic [63:0] pc, input logic taken);
        @(negedge clk_i);
        update_valid_i = 1'b1;
        update_pc_i    = pc;
        update_taken_i = taken;
        @(negedge clk_i);
        update_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] obs;
        for (int a = 0; a <= 'hFC; a += 4) begin
            vpc_i = 64'(a);
            #1;
            obs = {pred_valid_o, pred_taken_o};
            n_checks++;
            if (obs !== 4'b0000) begin
                $display("FAIL reset_sweep vpc=%h got=%b want=0000", vpc_i, obs);
                n_fail++;
            end
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        vpc_i = 64'h8000_0004;
        #1;
        obs = {pred_valid_o, pred_taken_o};
        n_checks++;
        if (obs !== 4'b0000) begin
            $display("FAIL reset_release got=%b want=0000", obs);
            n_fail++;
        end
    endtask

    task automatic test_train_saturate();
        // {valid[1:0], taken[1:0]} expected after each step at vpc 0x8000_0004
        logic       dir [14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [3:0] exp [14] = '{4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0100, 4'b0100,
                                 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0101, 4'b0100, 4'b0101};
        // counters:          2,3,3(sat),3(sat),2,1,0,0,0,0,1,2,1,2
        logic [3:0] obs;
        vpc_i = 64'h8000_0004;
        for (int k = 0; k < 14; k++) begin
            pulse_update(64'h8000_0004, dir[k]);
            #1;
            obs = {pred_valid_o, pred_taken_o};
            n_checks++;
            if (obs !== exp[k]) begin
                $display("FAIL train_step%0d got=%b want=%b", k, obs, exp[k]);
                n_fail++;
            end
        end
    endtask

    task automatic test_alias_slot();
        logic [3:0] obs;
        pulse_update(64'h8000_0002, 1'b0);
        vpc_i = 64'h8000_0102;
        #1;
        obs = {pred_valid_o, pred_taken_o};
        n_checks++;
        if (obs !== 4'b1000) begin
            $display("FAIL alias_slot1 got=%b want=1000", obs);
            n_fail++;
        end
        vpc_i = 64'h8000_0006;
        #1;
        obs = {pred_valid_o, pred_taken_o};
        n_checks++;
        if (obs !== 4'b0101) begin
            $display("FAIL other_row got=%b want=0101", obs);
            n_fail++;
        end
    endtask

    task automatic test_debug();
        logic [3:0] obs;
        debug_mode_i = 1'b1;
        for (int k = 0; k < 3; k++) pulse_update(64'h40, 1'b1);
        debug_mode_i = 1'b0;
        vpc_i = 64'h40;
        #1;
        obs = {pred_valid_o, pred_taken_o};
        n_checks++;
        if (obs !== 4'b0000) begin
            $display("FAIL debug_suppress got=%b want=0000", obs);
            n_fail++;
        end
    endtask

    task automatic test_flush();
        logic [3:0] obs;
        for (int k = 0; k < 3; k++) pulse_update(64'h80, 1'b1);
        pulse_update(64'h100, 1'b1);
        vpc_i = 64'h100;
        #1;
        obs = {pred_valid_o, pred_taken_o};
        n_checks++;
        if (obs !== 4'b1101) begin
            $display("FAIL preflush_row0 got=%b want=1101", obs);
            n_fail++;
        end
        vpc_i = 64'h80;
        #1;
        obs = {pred_valid_o, pred_taken_o};
        n_checks++;
        if (obs !== 4'b0101) begin
            $display("FAIL preflush_0x80 got=%b want=0101", obs);
            n_fail++;
        end
        @(negedge clk_i);
        flush_bp_i     = 1'b1;
        update_valid_i = 1'b1;
        update_pc_i    = 64'h80;
        update_taken_i = 1'b1;
        @(negedge clk_i);
        flush_bp_i     = 1'b0;
        update_valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vpc_i = (k == 0) ? 64'h80 : (k == 1) ? 64'h100 : 64'h8000_0004;
            #1;
            obs = {pred_valid_o, pred_taken_o};
            n_checks++;
            if (obs !== 4'b0000) begin
                $display("FAIL flush vpc=%h got=%b want=0000", vpc_i, obs);
                n_fail++;
            end
        end
    endtask

    task automatic test_collision();
        logic [3:0] obs;
        pulse_update(64'h80, 1'b0);
        vpc_i = 64'h80;
        @(negedge clk_i);
        update_valid_i = 1'b1;
        update_pc_i    = 64'h80;
        update_taken_i = 1'b1;
        #1;
        obs = {pred_valid_o, pred_taken_o};
        n_checks++;
        if (obs !== 4'b0100) begin
            $display("FAIL collide_same_cycle got=%b want=0100", obs);
            n_fail++;
        end
        @(negedge clk_i);
        update_valid_i = 1'b0;
        #1;
        obs = {pred_valid_o, pred_taken_o};
        n_checks++;
        if (obs !== 4'b0101) begin
            $display("FAIL collide_next_cycle got=%b want=0101", obs);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] obs;
        // Two consecutive not-taken cycles on a fresh entry: 1 then 0.
        @(negedge clk_i);
        update_valid_i = 1'b1;
        update_pc_i    = 64'hC0;
        update_taken_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        update_valid_i = 1'b0;
        // One taken: counter 1 (would be 2 if only one step had accumulated).
        pulse_update(64'hC0, 1'b1);
        vpc_i = 64'hC0;
        #1;
        obs = {pred_valid_o, pred_taken_o};
        n_checks++;
        if (obs !== 4'b0100) begin
            $display("FAIL back_to_back got=%b want=0100", obs);
            n_fail++;
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] obs;
        vpc_i = 64'h80;
        @(negedge clk_i);
        update_valid_i = 1'b1;
        update_pc_i    = 64'h80;
        update_taken_i = 1'b1;
        #2;
        rst_ni = 1'b0;
        #1;
        obs = {pred_valid_o, pred_taken_o};
        n_checks++;
        if (obs !== 4'b0000) begin
            $display("FAIL async_reset got=%b want=0000", obs);
            n_fail++;
        end
        @(negedge clk_i);
        update_valid_i = 1'b0;
        rst_ni = 1'b1;
        @(negedge clk_i);
        #1;
        obs = {pred_valid_o, pred_taken_o};
        n_checks++;
        if (obs !== 4'b0000) begin
            $display("FAIL post_reset got=%b want=0000", obs);
            n_fail++;
        end
    endtask

    initial begin
        rst_ni         = 1'b0;
        flush_bp_i     = 1'b0;
        debug_mode_i   = 1'b0;
        vpc_i          = 64'h0;
        update_valid_i = 1'b0;
        update_pc_i    = 64'h0;
        update_taken_i = 1'b0;
        test_reset();
        test_train_saturate();
        test_alias_slot();
        test_debug();
        test_flush();
        test_collision();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_history_table.md
# branch_history_table

Direction predictor feeding the frontend's branch-prediction stage. Holds NR_ENTRIES two-bit saturating counters, sized from the core configuration's BHTEntries field (128 in the 64-bit SV39 configuration). Returns a taken/not-taken prediction for every instruction slot of the current fetch block. Trained by resolved conditional branches from the execute stage.

## Interface
- XLEN, 64: virtual address width of vpc_i and update_pc_i.
- NR_ENTRIES, 128: total counters; power of two, ≥ 2*INSTR_PER_FETCH.
- INSTR_PER_FETCH, 2: 16-bit instruction slots per fetch block (RVC enabled); power of two.
- clk_i  in  1  core clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_bp_i  in  1  clear all predictor state.
- debug_mode_i  in  1  core in debug mode; suppresses training.
- vpc_i  in  XLEN  virtual PC of the current fetch block.
- update_valid_i  in  1  a resolved conditional branch is presented this cycle.
- update_pc_i  in  XLEN  PC of the resolved branch.
- update_taken_i  in  1  resolved direction (1 = taken).
- pred_valid_o  out  INSTR_PER_FETCH  per-slot: the entry has been trained.
- pred_taken_o  out  INSTR_PER_FETCH  per-slot predicted direction.

## Operation
- Storage: ROWS = NR_ENTRIES/INSTR_PER_FETCH rows × INSTR_PER_FETCH columns. Each entry holds a valid bit and a 2-bit counter (0 = strongly not taken … 3 = strongly taken).
- OFS = log2(INSTR_PER_FETCH), IDX = log2(ROWS).
- Column = pc[1 +: OFS]. Row = pc[1+OFS +: IDX]. Bit 0 is ignored. Default sizing: column = pc[1], row = pc[7:2].
- Aliasing is intended: PCs equal in pc[1+OFS+IDX-1:1] share an entry. There are no tags.
- Prediction for slot i reads row(vpc_i), column i:
  - pred_valid_o[i] = valid bit.
  - pred_taken_o[i] = valid & counter[1].
- Training takes effect when update_valid_i & ~debug_mode_i & ~flush_bp_i. It targets row/column of update_pc_i.
- Trained-entry update:
  - taken: counter = min(counter+1, 3).
  - not taken: counter = max(counter-1, 0).
  - Saturates; never wraps.
- First training of an invalid entry:
  - Sets valid.
  - counter = 2 if taken, 1 if not taken (weak state).
- Flush: all valid bits and counters cleared. Flush wins over a same-cycle update.
- At most one entry written per cycle. No other entry changes.

## Timing
- Reset (asynchronous assert): all entries invalid, counters 0. pred_valid_o = 0 and pred_taken_o = 0 on every slot while rst_ni is low.
- Prediction latency 0: outputs are combinational from vpc_i and the current state register contents.
- Update latency 1: a write sampled at edge N is visible on outputs after edge N.
- A same-cycle read and update of the same entry returns the pre-update value. No bypass.
- Flush asserted in cycle N: outputs are all-zero from cycle N+1 on.
- Reset asserted mid-operation: state clears immediately, regardless of pending update or flush.
- No handshake. update_valid_i is a single-cycle pulse per resolved branch. Back-to-back updates to the same entry accumulate, one step per cycle.

## Test plan
- Reset: hold rst_ni low, sweep vpc_i over 0x0–0xFC → every pred_valid_o/pred_taken_o = 0. Release reset → outputs still 0.
- First train and saturation:
  - Update pc 0x8000_0004 taken once → with vpc_i = 0x8000_0004: slot0 valid=1, taken=1 (counter 2); slot1 valid=0.
  - Two more taken updates → counter 3.
  - One not-taken → counter 2, still predicts taken.
  - Second not-taken → counter 1, predicts not taken.
  - Four further not-taken updates → counter holds at 0, valid stays 1.
- Aliasing and slot select:
  - Train pc 0x8000_0002 not-taken, then query vpc_i = 0x8000_0102 → slot1 valid=1, taken=0 (same entry).
  - Query vpc_i = 0x8000_0006 → slot1 valid=0.
- Debug suppression: debug_mode_i=1 with three taken updates to pc 0x40 → entry remains invalid.
- Flush priority: counter 3 at pc 0x80; assert flush_bp_i together with a taken update to pc 0x80 → next cycle valid=0 at both pc 0x80 and a previously trained pc 0x100.
- Read/write collision: vpc_i = 0x80 while updating pc 0x80 from counter 1 (taken) → same-cycle pred_taken_o[0]=0, next cycle pred_taken_o[0]=1.
